// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the multicycle CPU front end:
//     - PCSource encodings driven by the controller
//     - instruction field bit positions (32-bit instruction word)
//     - NOP opcode
//     - fetch FSM state type used by fetch_pc_unit
//   No ports (package).
// ---------------------------------------------------------------------------
package cpu_pkg;

   // Next-PC select codes; 3 is reserved and leaves the PC untouched.
   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'd0,
      PCSRC_ALUOUT = 2'd1,
      PCSRC_JUMP   = 2'd2,
      PCSRC_RSVD   = 2'd3
   } pcsrc_e;

   // Instruction field positions.
   localparam int OPC_HI = 31;
   localparam int OPC_LO = 26;
   localparam int RD_HI  = 25;
   localparam int RD_LO  = 21;
   localparam int RS1_HI = 20;
   localparam int RS1_LO = 16;
   localparam int RS2_HI = 15;
   localparam int RS2_LO = 11;
   localparam int IMM_HI = 15;
   localparam int IMM_LO = 0;

   // Width of the jump target field ir[25:0].
   localparam int JTGT_W = 26;

   localparam logic [5:0] OPC_NOP = 6'b000000;

   // Fetch handshake FSM.
   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } fetch_state_e;

endpackage : cpu_pkg

// File: rtl/fetch_pc_unit_ir_decode.sv
// ---------------------------------------------------------------------------
// ir_decode
//   Purely combinational slicing of the instruction register into the
//   fields consumed by the controller and the datapath.
//
//   Ports:
//     ir      in  INSTR_W  instruction register contents
//     opcode  out 6        ir[31:26]
//     rd      out 5        ir[25:21]
//     rs1     out 5        ir[20:16]
//     rs2     out 5        ir[15:11]
//     imm     out 16       ir[15:0]
// ---------------------------------------------------------------------------
module ir_decode
   import cpu_pkg::*;
#(
   parameter int INSTR_W = 32
) (
   input  logic [INSTR_W-1:0] ir,
   output logic [5:0]         opcode,
   output logic [4:0]         rd,
   output logic [4:0]         rs1,
   output logic [4:0]         rs2,
   output logic [15:0]        imm
);

   assign opcode = ir[OPC_HI:OPC_LO];
   assign rd     = ir[RD_HI:RD_LO];
   assign rs1    = ir[RS1_HI:RS1_LO];
   assign rs2    = ir[RS2_HI:RS2_LO];
   assign imm    = ir[IMM_HI:IMM_LO];

endmodule : ir_decode

// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit
//   Program counter and instruction register of the multicycle CPU.
//   Applies the controller's PCWrite / PCWriteCond / PCSource / IRWrite
//   strobes, and handshakes with a variable-latency instruction memory,
//   raising stall while a fetch is outstanding.
//
//   Parameters:
//     PC_W      PC / instruction address width (must exceed 26)
//     RESET_PC  PC value loaded on reset
//     INSTR_W   instruction width (field layout assumes 32)
//
//   Ports:
//     clk          in   rising-edge clock
//     reset        in   synchronous active-high reset
//     PCWrite      in   unconditional PC load
//     PCWriteCond  in   PC load qualified by zero
//     PCSource     in 2 next-PC select (cpu_pkg::pcsrc_e)
//     IRWrite      in   capture the fetched instruction
//     zero         in   ALU zero flag
//     alu_result   in   combinational ALU output (PC+1 during fetch)
//     alu_out      in   registered ALU output (branch target)
//     imem_rdata   in   instruction memory read data
//     imem_rvalid  in   imem_rdata valid this cycle
//     imem_addr    out  fetch address (= pc)
//     imem_req     out  fetch request
//     pc           out  current PC
//     opcode/rd/rs1/rs2/imm  out  decoded IR fields
//     stall        out  fetch outstanding, controller holds its state
//
//   Optional build macro FETCH_PERF_EN adds:
//     instr_count  out 32  IR captures since reset
//     stall_count  out 32  stalled cycles since reset
// ---------------------------------------------------------------------------
module fetch_pc_unit
   import cpu_pkg::*;
#(
   parameter int                PC_W     = 32,
   parameter logic [PC_W-1:0]   RESET_PC = '0,
   parameter int                INSTR_W  = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               PCWrite,
   input  logic               PCWriteCond,
   input  logic [1:0]         PCSource,
   input  logic               IRWrite,
   input  logic               zero,
   input  logic [PC_W-1:0]    alu_result,
   input  logic [PC_W-1:0]    alu_out,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_rvalid,
   output logic [PC_W-1:0]    imem_addr,
   output logic               imem_req,
   output logic [PC_W-1:0]    pc,
   output logic [5:0]         opcode,
   output logic [4:0]         rd,
   output logic [4:0]         rs1,
   output logic [4:0]         rs2,
   output logic [15:0]        imm,
   output logic               stall
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]        instr_count,
   output logic [31:0]        stall_count
`endif
);

   fetch_state_e        state;
   fetch_state_e        state_next;
   logic [INSTR_W-1:0]  ir;
   logic                ir_load;
   logic                pc_load;
   logic [PC_W-1:0]     pc_next;
   logic [PC_W-1:0]     jump_pc;

   // Fetch FSM: state register, PC and IR.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         pc    <= RESET_PC;
         ir    <= '0;
      end else begin
         state <= state_next;
         if (ir_load) begin
            ir <= imem_rdata;
         end
         if (pc_load) begin
            pc <= pc_next;
         end
      end
   end

   // Next-state and handshake decode.
   // A fetch that completes in WAIT drops stall in that same cycle, so the
   // PC+1 load the controller is still presenting lands together with the
   // IR capture. In IDLE, rvalid without IRWrite is ignored, which also
   // discards any late response to a fetch that was cut short by reset.
   always_comb begin
      state_next = state;
      stall      = 1'b0;
      ir_load    = 1'b0;
      unique case (state)
         IDLE: begin
            if (IRWrite) begin
               if (imem_rvalid) begin
                  ir_load = 1'b1;
               end else begin
                  stall      = 1'b1;
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               ir_load    = 1'b1;
               state_next = IDLE;
            end else begin
               stall = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign imem_req  = IRWrite | (state == WAIT);
   assign imem_addr = pc;

   // Unconditional load takes priority simply by OR-ing; a stalled fetch
   // must not advance the PC until the instruction has arrived.
   assign pc_load = (PCWrite | (PCWriteCond & zero)) & ~stall;

   // Jump keeps the PC's upper bits and splices in the 26-bit target.
   always_comb begin
      jump_pc                = pc;
      jump_pc[JTGT_W-1:0]    = ir[JTGT_W-1:0];
   end

   always_comb begin
      pc_next = pc;
      case (pcsrc_e'(PCSource))
         PCSRC_ALU:    pc_next = alu_result;
         PCSRC_ALUOUT: pc_next = alu_out;
         PCSRC_JUMP:   pc_next = jump_pc;
         default:      pc_next = pc;
      endcase
   end

   ir_decode #(
      .INSTR_W (INSTR_W)
   ) u_ir_decode (
      .ir     (ir),
      .opcode (opcode),
      .rd     (rd),
      .rs1    (rs1),
      .rs2    (rs2),
      .imm    (imm)
   );

`ifdef FETCH_PERF_EN
   // Free-running event counters; wrap naturally at 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_count <= '0;
         stall_count <= '0;
      end else begin
         if (ir_load) begin
            instr_count <= instr_count + 32'd1;
         end
         if (stall) begin
            stall_count <= stall_count + 32'd1;
         end
      end
   end
`endif

endmodule : fetch_pc_unit

// File: tb/tb_fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_unit
//   Directed, table-driven bench for fetch_pc_unit, plus hand-written
//   sequences for the wait-state fetch, reset during WAIT and (when
//   FETCH_PERF_EN is defined) the performance counters.
// ---------------------------------------------------------------------------
module tb_fetch_pc_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        PCWrite;
   logic        PCWriteCond;
   logic [1:0]  PCSource;
   logic        IRWrite;
   logic        zero;
   logic [31:0] alu_result;
   logic [31:0] alu_out;
   logic [31:0] imem_rdata;
   logic        imem_rvalid;
   logic [31:0] imem_addr;
   logic        imem_req;
   logic [31:0] pc;
   logic [5:0]  opcode;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [15:0] imm;
   logic        stall;
`ifdef FETCH_PERF_EN
   logic [31:0] instr_count;
   logic [31:0] stall_count;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fetch_pc_unit dut (
      .clk         (clk),
      .reset       (reset),
      .PCWrite     (PCWrite),
      .PCWriteCond (PCWriteCond),
      .PCSource    (PCSource),
      .IRWrite     (IRWrite),
      .zero        (zero),
      .alu_result  (alu_result),
      .alu_out     (alu_out),
      .imem_rdata  (imem_rdata),
      .imem_rvalid (imem_rvalid),
      .imem_addr   (imem_addr),
      .imem_req    (imem_req),
      .pc          (pc),
      .opcode      (opcode),
      .rd          (rd),
      .rs1         (rs1),
      .rs2         (rs2),
      .imm         (imm),
      .stall       (stall)
`ifdef FETCH_PERF_EN
      ,
      .instr_count (instr_count),
      .stall_count (stall_count)
`endif
   );

   typedef struct {
      logic        pcw;
      logic        pcwc;
      logic [1:0]  src;
      logic        irw;
      logic        z;
      logic [31:0] ar;
      logic [31:0] ao;
      logic [31:0] rdata;
      logic        rv;
      logic        exp_stall;
      logic        exp_req;
      logic [31:0] exp_pc;
      logic [31:0] exp_ir;
   } vec_t;

   localparam int NVEC = 12;
   vec_t vecs [NVEC];

   function automatic vec_t mk(input logic pcw, input logic pcwc,
                               input logic [1:0] src, input logic irw,
                               input logic z, input logic [31:0] ar,
                               input logic [31:0] ao, input logic [31:0] rdata,
                               input logic rv, input logic es, input logic eq,
                               input logic [31:0] epc, input logic [31:0] eir);
      vec_t v;
      v.pcw = pcw; v.pcwc = pcwc; v.src = src; v.irw = irw; v.z = z;
      v.ar = ar; v.ao = ao; v.rdata = rdata; v.rv = rv;
      v.exp_stall = es; v.exp_req = eq; v.exp_pc = epc; v.exp_ir = eir;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic chk_ir(input string tag, input logic [31:0] e);
      chk({tag, "_opcode"}, 32'(opcode), 32'(e[31:26]));
      chk({tag, "_rd"},     32'(rd),     32'(e[25:21]));
      chk({tag, "_rs1"},    32'(rs1),    32'(e[20:16]));
      chk({tag, "_rs2"},    32'(rs2),    32'(e[15:11]));
      chk({tag, "_imm"},    32'(imm),    32'(e[15:0]));
   endtask

   // Drive one cycle's worth of inputs on the falling edge.
   task automatic drive(input logic pcw, input logic pcwc, input logic [1:0] src,
                        input logic irw, input logic z, input logic [31:0] ar,
                        input logic [31:0] ao, input logic [31:0] rdata,
                        input logic rv);
      @(negedge clk);
      PCWrite = pcw; PCWriteCond = pcwc; PCSource = src; IRWrite = irw;
      zero = z; alu_result = ar; alu_out = ao; imem_rdata = rdata;
      imem_rvalid = rv;
      #1;
   endtask

   task automatic edge_settle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      PCWrite = 1'b0; PCWriteCond = 1'b0; PCSource = 2'd0; IRWrite = 1'b0;
      zero = 1'b0; alu_result = '0; alu_out = '0; imem_rdata = '0;
      imem_rvalid = 1'b0;

      //            pcw pcwc src  irw z  alu_result     alu_out        rdata          rv  stall req  exp_pc         exp_ir
      vecs[0]  = mk(1, 0, 2'd0, 1, 0, 32'h0000_0001, 32'h0,         32'h4800_0000, 1,  0, 1, 32'h0000_0001, 32'h4800_0000);
      vecs[1]  = mk(1, 0, 2'd0, 0, 0, 32'h0000_0005, 32'h0,         32'h0,         0,  0, 0, 32'h0000_0005, 32'h4800_0000);
      vecs[2]  = mk(0, 1, 2'd1, 0, 0, 32'h0,         32'h0000_0020, 32'h0,         0,  0, 0, 32'h0000_0005, 32'h4800_0000);
      vecs[3]  = mk(0, 1, 2'd1, 0, 1, 32'h0,         32'h0000_0020, 32'h0,         0,  0, 0, 32'h0000_0020, 32'h4800_0000);
      vecs[4]  = mk(1, 1, 2'd1, 0, 0, 32'h0,         32'h0000_0040, 32'h0,         0,  0, 0, 32'h0000_0040, 32'h4800_0000);
      vecs[5]  = mk(1, 0, 2'd3, 0, 1, 32'h0000_0099, 32'h0000_0088, 32'h0,         0,  0, 0, 32'h0000_0040, 32'h4800_0000);
      vecs[6]  = mk(1, 0, 2'd0, 1, 0, 32'h1000_0004, 32'h0,         32'h0400_0123, 1,  0, 1, 32'h1000_0004, 32'h0400_0123);
      vecs[7]  = mk(1, 0, 2'd2, 0, 0, 32'h0,         32'h0,         32'h0,         0,  0, 0, 32'h1000_0123, 32'h0400_0123);
      vecs[8]  = mk(0, 0, 2'd0, 0, 0, 32'h0,         32'h0,         32'hDEAD_BEEF, 1,  0, 0, 32'h1000_0123, 32'h0400_0123);
      vecs[9]  = mk(1, 0, 2'd1, 0, 0, 32'h0,         32'hFFFF_FFFF, 32'h0,         0,  0, 0, 32'hFFFF_FFFF, 32'h0400_0123);
      vecs[10] = mk(1, 0, 2'd2, 0, 0, 32'h0,         32'h0,         32'h0,         0,  0, 0, 32'hFC00_0123, 32'h0400_0123);
      vecs[11] = mk(1, 0, 2'd0, 0, 0, 32'h0000_0000, 32'h0,         32'h0,         0,  0, 0, 32'h0000_0000, 32'h0400_0123);

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_pc",       pc,              32'h0);
      chk("rst_imem_addr", imem_addr,      32'h0);
      chk("rst_opcode",   32'(opcode),     32'h0);
      chk("rst_stall",    32'(stall),      32'h0);
      chk("rst_req",      32'(imem_req),   32'h0);
`ifdef FETCH_PERF_EN
      chk("rst_instr_count", instr_count,  32'h0);
      chk("rst_stall_count", stall_count,  32'h0);
`endif

      // Table-driven single-cycle vectors
      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i].pcw, vecs[i].pcwc, vecs[i].src, vecs[i].irw, vecs[i].z,
               vecs[i].ar, vecs[i].ao, vecs[i].rdata, vecs[i].rv);
         chk($sformatf("v%0d_stall", i), 32'(stall),    32'(vecs[i].exp_stall));
         chk($sformatf("v%0d_req", i),   32'(imem_req), 32'(vecs[i].exp_req));
         edge_settle();
         chk($sformatf("v%0d_pc", i),    pc,        vecs[i].exp_pc);
         chk($sformatf("v%0d_addr", i),  imem_addr, vecs[i].exp_pc);
         chk_ir($sformatf("v%0d", i), vecs[i].exp_ir);
      end

      // Wait-state fetch: three stalled cycles, then data arrives
      for (int c = 0; c < 3; c++) begin
         drive(1, 0, 2'd0, 1, 0, 32'h0000_0077, 32'h0, 32'hC800_0005, 0);
         chk($sformatf("ws%0d_stall", c), 32'(stall),    32'h1);
         chk($sformatf("ws%0d_req", c),   32'(imem_req), 32'h1);
         edge_settle();
         chk($sformatf("ws%0d_pc", c), pc, 32'h0);
         chk($sformatf("ws%0d_opcode", c), 32'(opcode), 32'(6'b000001));
      end
      drive(1, 0, 2'd0, 1, 0, 32'h0000_0077, 32'h0, 32'hC800_0005, 1);
      chk("ws_done_stall", 32'(stall),    32'h0);
      chk("ws_done_req",   32'(imem_req), 32'h1);
      edge_settle();
      chk("ws_done_pc", pc, 32'h0000_0077);
      chk_ir("ws_done", 32'hC800_0005);
      drive(0, 0, 2'd0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
      chk("ws_idle_stall", 32'(stall),    32'h0);
      chk("ws_idle_req",   32'(imem_req), 32'h0);
      edge_settle();

      // Reset while WAITing, with a late response arriving during/after reset
      drive(1, 0, 2'd0, 1, 0, 32'h0000_0099, 32'h0, 32'h0, 0);
      chk("rw_enter_stall", 32'(stall), 32'h1);
      edge_settle();
      drive(1, 0, 2'd0, 1, 0, 32'h0000_0099, 32'h0, 32'hFFFF_FFFF, 1);
      reset = 1'b1;
      edge_settle();
      chk("rw_pc", pc, 32'h0);
      chk_ir("rw", 32'h0);
      drive(0, 0, 2'd0, 0, 0, 32'h0, 32'h0, 32'hFFFF_FFFF, 1);
      reset = 1'b0;
      #1;
      chk("rw_late_stall", 32'(stall),    32'h0);
      chk("rw_late_req",   32'(imem_req), 32'h0);
      edge_settle();
      chk("rw_late_pc", pc, 32'h0);
      chk_ir("rw_late", 32'h0);

`ifdef FETCH_PERF_EN
      // Four fetches, the second of which waits two cycles
      drive(0, 0, 2'd0, 1, 0, 32'h0, 32'h0, 32'h0400_0001, 1);
      edge_settle();
      drive(0, 0, 2'd0, 1, 0, 32'h0, 32'h0, 32'h0800_0002, 0);
      edge_settle();
      drive(0, 0, 2'd0, 1, 0, 32'h0, 32'h0, 32'h0800_0002, 0);
      edge_settle();
      drive(0, 0, 2'd0, 1, 0, 32'h0, 32'h0, 32'h0800_0002, 1);
      edge_settle();
      drive(0, 0, 2'd0, 1, 0, 32'h0, 32'h0, 32'h0C00_0003, 1);
      edge_settle();
      drive(0, 0, 2'd0, 1, 0, 32'h0, 32'h0, 32'h1000_0004, 1);
      edge_settle();
      drive(0, 0, 2'd0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
      edge_settle();
      chk("perf_instr_count", instr_count, 32'd4);
      chk("perf_stall_count", stall_count, 32'd2);
      chk_ir("perf_last", 32'h1000_0004);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_fetch_pc_unit
